regfile_write_arbiter: RTL and testbench

//  Shares the single RegisterFile write port (registerWrite/writeAddress/writeData) between NUM_REQ

---
 rtl/rf_arb_pkg.sv | 29 ++
 rtl/rf_rr_grant.sv | 52 +++++
 rtl/regfile_write_arbiter.sv | 149 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and helpers for the register-file write arbiter
// Purpose: default widths, register-file address/data types, writeback request
//          record, arbiter FSM state encoding and a round-robin index wrap helper.
// Ports:   none (package).
package rf_arb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  typedef struct packed {
    rf_addr_t addr;
    rf_data_t data;
  } wb_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_HELD  = 2'd2
  } arb_state_e;

  // Wraps a search position that may run one lap past the last requester.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/rf_rr_grant.sv
// rtl/rf_rr_grant.sv - round-robin one-hot grant with priority pointer
// Purpose: picks at most one valid requester per cycle, searching from the
//          priority pointer upward; pointer moves to (grant+1) mod NUM_REQ on a grant.
// Ports:   clk, rst       clock, asynchronous active-high reset
//          enable         grants allowed this cycle
//          valid          per-requester pending flag
//          grant          one-hot grant (only ever set where valid is set)
//          any_grant      a grant was issued this cycle
//          grant_idx      binary index of the granted requester
module rf_rr_grant
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic               any_grant,
  output logic [PTR_W-1:0]   grant_idx
);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] idx_p;

  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    grant_idx = '0;
    idx_p     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_p = PTR_W'(rr_wrap(int'(ptr) + i, NUM_REQ));
      if (enable && !any_grant && valid[idx_p]) begin
        grant[idx_p] = 1'b1;
        any_grant    = 1'b1;
        grant_idx    = idx_p;
      end
    end
  end

  // ptr holds the first index to search, so the last winner gets lowest priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (any_grant) begin
      ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the register-file write port plus busy scoreboard
// Purpose: shares one RegisterFile write port among NUM_REQ writeback sources with
//          valid/ready handshakes, and tracks per-register busy bits for RAW checks.
//          Optional macro RF_ARB_FORWARD_EN adds write-port forwarding hits to decode.
// Ports:   clk, rst                      clock, asynchronous active-high reset
//          req_valid/req_addr/req_data   writeback requests
//          req_ready                     one-hot grant (combinational)
//          rf_hold                       stall the write port
//          registerWrite/writeAddress/writeData  RegisterFile write port
//          reserve_valid/reserve_addr    decode destination claim
//          rsAddress/rtAddress           decode source lookups
//          rs_busy/rt_busy               busy status of the sources (combinational)
//          rs_fwd_hit/rt_fwd_hit/fwd_data  forwarding (RF_ARB_FORWARD_EN only)
module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           rf_hold,
  output logic                           registerWrite,
  output logic [ADDR_W-1:0]              writeAddress,
  output logic [DATA_W-1:0]              writeData,
  input  logic                           reserve_valid,
  input  logic [ADDR_W-1:0]              reserve_addr,
  input  logic [ADDR_W-1:0]              rsAddress,
  input  logic [ADDR_W-1:0]              rtAddress,
  output logic                           rs_busy,
  output logic                           rt_busy
`ifdef RF_ARB_FORWARD_EN
  ,
  output logic                           rs_fwd_hit,
  output logic                           rt_fwd_hit,
  output logic [1:0][DATA_W-1:0]         fwd_data
`endif
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state, state_next;
  logic                grant_en;
  logic                any_grant;
  logic [PTR_W-1:0]    grant_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                accept;
  logic [NUM_REGS-1:0] busy, set_vec, clr_vec;

  // No grants during reset, while the port is stalled, or while an entry waits in HELD.
  assign grant_en = !rst && !rf_hold && (state != ARB_HELD);

  rf_rr_grant #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .enable    (grant_en),
    .valid     (req_valid),
    .grant     (req_ready),
    .any_grant (any_grant),
    .grant_idx (grant_idx)
  );

  assign sel_addr = req_addr[grant_idx];
  assign sel_data = req_data[grant_idx];
  // Writes to register 0 complete the handshake but never become an entry.
  assign accept   = any_grant && (sel_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE, ARB_ISSUE: begin
        if (state == ARB_ISSUE && rf_hold) begin
          state_next = ARB_HELD;
        end else if (accept) begin
          state_next = ARB_ISSUE;
        end else begin
          state_next = ARB_IDLE;
        end
      end
      ARB_HELD: state_next = rf_hold ? ARB_HELD : ARB_ISSUE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // A stall arriving in ISSUE suppresses that cycle's write; the entry is
  // retried from HELD so exactly one pulse reaches the register file.
  always_comb begin
    registerWrite = (state == ARB_ISSUE) && !rf_hold;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      writeAddress <= '0;
      writeData    <= '0;
    end else if (accept) begin
      writeAddress <= sel_addr;
      writeData    <= sel_data;
    end
  end

  always_comb begin
    set_vec = reserve_valid ? (NUM_REGS'(1) << reserve_addr) : '0;
    clr_vec = registerWrite ? (NUM_REGS'(1) << writeAddress) : '0;
  end

  // Set is applied after clear so a same-cycle reserve keeps the register busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~clr_vec) | set_vec) & ~NUM_REGS'(1);
    end
  end

`ifdef RF_ARB_FORWARD_EN
  always_comb begin
    rs_fwd_hit  = registerWrite && (writeAddress == rsAddress) && (rsAddress != '0);
    rt_fwd_hit  = registerWrite && (writeAddress == rtAddress) && (rtAddress != '0);
    fwd_data[0] = writeData;
    fwd_data[1] = writeData;
    rs_busy     = busy[rsAddress] && !rs_fwd_hit;
    rt_busy     = busy[rtAddress] && !rt_fwd_hit;
  end
`else
  always_comb begin
    rs_busy = busy[rsAddress];
    rt_busy = busy[rtAddress];
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  import rf_arb_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  logic                           clk;
  logic                           rst;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           rf_hold;
  logic                           registerWrite;
  logic [ADDR_W-1:0]              writeAddress;
  logic [DATA_W-1:0]              writeData;
  logic                           reserve_valid;
  logic [ADDR_W-1:0]              reserve_addr;
  logic [ADDR_W-1:0]              rsAddress;
  logic [ADDR_W-1:0]              rtAddress;
  logic                           rs_busy;
  logic                           rt_busy;
`ifdef RF_ARB_FORWARD_EN
  logic                           rs_fwd_hit;
  logic                           rt_fwd_hit;
  logic [1:0][DATA_W-1:0]         fwd_data;
`endif

  typedef struct {
    wb_req_t req;
    int      due;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  bit   held       = 0;

  regfile_write_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rf_hold       (rf_hold),
    .registerWrite (registerWrite),
    .writeAddress  (writeAddress),
    .writeData     (writeData),
    .reserve_valid (reserve_valid),
    .reserve_addr  (reserve_addr),
    .rsAddress     (rsAddress),
    .rtAddress     (rtAddress),
    .rs_busy       (rs_busy),
    .rt_busy       (rt_busy)
`ifdef RF_ARB_FORWARD_EN
    ,
    .rs_fwd_hit    (rs_fwd_hit),
    .rt_fwd_hit    (rt_fwd_hit),
    .fwd_data      (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Checks one cycle at the falling edge, then advances past the next rising edge.
  // Expected writes come from the queue; a stalled entry slips one cycle per held
  // cycle plus one more for the HELD->ISSUE transition.
  task automatic step(input logic [NUM_REQ-1:0] exp_ready, input int exp_rs = -1, input int exp_rt = -1);
    bit   exp_we;
    exp_t e;
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    exp_we = (q.size() > 0) && (q[0].due == cyc) && !rf_hold && !held;
    chk("registerWrite", 64'(registerWrite), 64'(exp_we));
    if (exp_we) begin
      e = q.pop_front();
      chk("writeAddress", 64'(writeAddress), 64'(e.req.addr));
      chk("writeData", 64'(writeData), 64'(e.req.data));
    end else if (q.size() > 0 && q[0].due == cyc) begin
      q[0].due = q[0].due + 1;
      held = rf_hold;
    end
    if (exp_rs >= 0) chk("rs_busy", 64'(rs_busy), 64'(exp_rs));
    if (exp_rt >= 0) chk("rt_busy", 64'(rt_busy), 64'(exp_rt));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (exp_ready[i] && req_addr[i] != '0) begin
        e.req.addr = req_addr[i];
        e.req.data = req_data[i];
        e.due      = cyc + 1;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; rf_hold = 1'b0;
    reserve_valid = 1'b0; reserve_addr = '0; rsAddress = '0; rtAddress = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    step('0, 0, 0);
    chk("rst_writeAddress", 64'(writeAddress), 64'd0);
    chk("rst_writeData", 64'(writeData), 64'd0);
    rst = 1'b0;

    // Single write: ready pulse, then one write cycle
    req_valid = 3'b001; req_addr[0] = 5'd12; req_data[0] = 32'd1234;
    step(3'b001, 0);
    req_valid = '0;
    step('0);
    step('0);

    // Round robin from a fresh pointer
    rst = 1'b1;
    step('0);
    rst = 1'b0;
    req_valid = 3'b111;
    req_addr[0] = 5'd1; req_data[0] = 32'h100;
    req_addr[1] = 5'd2; req_data[1] = 32'h200;
    req_addr[2] = 5'd3; req_data[2] = 32'h300;
    step(3'b001); step(3'b010); step(3'b100);
    step(3'b001); step(3'b010); step(3'b100);
    req_valid = '0;
    step('0);
    step('0);

    // Address 0: handshake only, no write, busy[0] stays 0
    req_valid = 3'b010; req_addr[1] = 5'd0; req_data[1] = 32'd1234;
    reserve_valid = 1'b1; reserve_addr = 5'd0;
    step(3'b010, 0);
    req_valid = '0; reserve_valid = 1'b0;
    step('0, 0);

    // Stall: accepted write held 3 cycles, no grants while held, one pulse after
    req_valid = 3'b001; req_addr[0] = 5'd5; req_data[0] = 32'(-555555);
    step(3'b001);
    req_valid = 3'b010; req_addr[1] = 5'd7; req_data[1] = 32'h77;
    rf_hold = 1'b1;
    step('0); step('0); step('0);
    rf_hold = 1'b0;
    step('0);
    step(3'b010);
    req_valid = '0;
    step('0);
    step('0);

    // Scoreboard: reserve, clear on write, same-cycle reserve wins
    rsAddress = 5'd12; rtAddress = 5'd13;
    reserve_valid = 1'b1; reserve_addr = 5'd12;
    step('0, 0, 0);
    reserve_valid = 1'b0;
    step('0, 1, 0);
    req_valid = 3'b100; req_addr[2] = 5'd12; req_data[2] = 32'hABC;
    step(3'b100, 1, 0);
    req_valid = '0;
    step('0, 1, 0);
    step('0, 0, 0);
    reserve_valid = 1'b1;
    step('0, 0, 0);
    reserve_valid = 1'b0;
    req_valid = 3'b001; req_addr[0] = 5'd12; req_data[0] = 32'h1;
    step(3'b001, 1, 0);
    req_valid = '0; reserve_valid = 1'b1;
    step('0, 1, 0);
    reserve_valid = 1'b0; rtAddress = 5'd12;
    step('0, 1, 1);

    // Reset while HELD: held write discarded, busy cleared, no stale pulse
    req_valid = 3'b010; req_addr[1] = 5'd20; req_data[1] = 32'd1234;
    step(3'b010, 1, 1);
    req_valid = '0; rf_hold = 1'b1;
    step('0);
    step('0);
    rst = 1'b1; rf_hold = 1'b0; q.delete(); held = 1'b0;
    step('0, 0, 0);
    chk("held_rst_writeAddress", 64'(writeAddress), 64'd0);
    chk("held_rst_writeData", 64'(writeData), 64'd0);
    rst = 1'b0;
    step('0, 0, 0);
    step('0, 0, 0);
    step('0, 0, 0);

    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
